number_on3_7seg: RTL and testbench

NUMBER_ON3_7SEG -- requirements
Module: number_on3_7seg

---
 rtl/number_on3_7seg_pkg.sv | 41 ++++
 rtl/seg7_decode.sv | 35 +++
 rtl/number_on3_7seg.sv | 103 ++++++++++
 tb/tb_number_on3_7seg.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/number_on3_7seg_pkg.sv
// Shared constants and types for the 3-digit multiplexed 7-segment driver.
// Holds the value width/limit, the active-high segment patterns ({dp,g,f,e,d,c,b,a})
// and the scan-index type, plus a helper that extracts one decimal digit.
package number_on3_7seg_pkg;

  localparam int unsigned NUM_W = 10;
  localparam logic [NUM_W-1:0] NUM_MAX = 10'd999;

  // Logical (active-high) segment patterns; dp is always off.
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Scan index: which digit is driven on the current edge.
  typedef enum logic [1:0] {
    IdxUnits = 2'd0,
    IdxTens  = 2'd1,
    IdxHunds = 2'd2
  } idx_t;

  // Decimal digit of v at position pos (units/tens/hundreds).
  function automatic logic [3:0] bcd_digit(input logic [NUM_W-1:0] v, input idx_t pos);
    logic [3:0] d;
    case (pos)
      IdxUnits: d = 4'(v % 10);
      IdxTens:  d = 4'((v / 10) % 10);
      default:  d = 4'(v / 100);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Single-digit 7-segment decoder producing an active-high {dp,g,f,e,d,c,b,a} pattern.
// Ports:
//   digit_i  4-bit decimal digit (10..15 decode to blank)
//   blank_i  force all segments off
//   dash_i   force the dash pattern; takes priority over blank_i
//   seg_o    active-high segment pattern
module seg7_decode
  import number_on3_7seg_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
    if (blank_i) seg_o = SEG_BLANK;
    if (dash_i)  seg_o = SEG_DASH;
  end

endmodule

// File: rtl/number_on3_7seg.sv
// Three-digit multiplexed 7-segment display driver.
// Each seg_sw_clk rising edge drives one digit (units -> tens -> hundreds) with registered
// Seg/Dig outputs. Num is latched on the units edge so tens/hundreds of a frame always come
// from the same value (tear-free); values above 999 show a dash on every digit.
// Optional build macro NUMBER_ON3_7SEG_LZB_EN enables leading-zero blanking.
// Ports:
//   seg_sw_clk  scan clock
//   rst_n       asynchronous active-low reset
//   Num         value to display (0..999 valid)
//   Seg         segment drive {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   Dig         one-hot digit enable (bit 0 units), polarity per DIG_ACTIVE_LOW
module number_on3_7seg
  import number_on3_7seg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic             seg_sw_clk,
  input  logic             rst_n,
  input  logic [NUM_W-1:0] Num,
  output logic [7:0]       Seg,
  output logic [2:0]       Dig
);

  localparam logic [7:0] SegOff = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [2:0] DigOff = DIG_ACTIVE_LOW ? 3'b111 : 3'b000;

  idx_t             idx_q, idx_d;
  logic [NUM_W-1:0] num_lat_q, num_lat_d;
  logic [7:0]       seg_q, seg_d;
  logic [2:0]       dig_q, dig_d;

  logic [NUM_W-1:0] cur_val;
  logic [3:0]       digit;
  logic             blank;
  logic             dash;
  logic [7:0]       seg_pat;
  logic [2:0]       dig_onehot;

  always_ff @(posedge seg_sw_clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= IdxUnits;
      num_lat_q <= '0;
      seg_q     <= SegOff;
      dig_q     <= DigOff;
    end else begin
      idx_q     <= idx_d;
      num_lat_q <= num_lat_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
    end
  end

  always_comb begin
    idx_d = IdxUnits;
    case (idx_q)
      IdxUnits: idx_d = IdxTens;
      IdxTens:  idx_d = IdxHunds;
      default:  idx_d = IdxUnits;
    endcase
  end

  // Units take Num directly so the freshly latched value is visible on the latching edge.
  always_comb begin
    cur_val   = (idx_q == IdxUnits) ? Num : num_lat_q;
    num_lat_d = (idx_q == IdxUnits) ? Num : num_lat_q;
    dash      = (cur_val > NUM_MAX);
    digit     = bcd_digit(cur_val, idx_q);
`ifdef NUMBER_ON3_7SEG_LZB_EN
    case (idx_q)
      IdxHunds: blank = (bcd_digit(cur_val, IdxHunds) == 4'd0);
      IdxTens:  blank = (bcd_digit(cur_val, IdxHunds) == 4'd0) &&
                        (bcd_digit(cur_val, IdxTens) == 4'd0);
      default:  blank = 1'b0;
    endcase
`else
    blank     = 1'b0;
`endif
  end

  seg7_decode u_decode (
    .digit_i (digit),
    .blank_i (blank),
    .dash_i  (dash),
    .seg_o   (seg_pat)
  );

  always_comb begin
    dig_onehot = 3'b000;
    case (idx_q)
      IdxUnits: dig_onehot = 3'b001;
      IdxTens:  dig_onehot = 3'b010;
      IdxHunds: dig_onehot = 3'b100;
      default:  dig_onehot = 3'b000;
    endcase
    seg_d = SEG_ACTIVE_LOW ? ~seg_pat : seg_pat;
    dig_d = DIG_ACTIVE_LOW ? ~dig_onehot : dig_onehot;
  end

  assign Seg = seg_q;
  assign Dig = dig_q;

endmodule

// File: tb/tb_number_on3_7seg.sv
module tb_number_on3_7seg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] num;
  logic [7:0] seg, seg_ah;
  logic [2:0] dig, dig_ah;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  number_on3_7seg dut (
    .seg_sw_clk (clk),
    .rst_n      (rst_n),
    .Num        (num),
    .Seg        (seg),
    .Dig        (dig)
  );

  number_on3_7seg #(
    .SEG_ACTIVE_LOW (1'b0),
    .DIG_ACTIVE_LOW (1'b0)
  ) dut_ah (
    .seg_sw_clk (clk),
    .rst_n      (rst_n),
    .Num        (num),
    .Seg        (seg_ah),
    .Dig        (dig_ah)
  );

  logic [7:0] pat_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

`ifdef NUMBER_ON3_7SEG_LZB_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  typedef struct {
    logic [9:0] num;
    logic [2:0] dig;
    logic [7:0] seg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", name, got, exp);
    end
  endtask

  // Logical pattern for digit position pos (0 units) of value v.
  function automatic logic [7:0] pattern(input int v, input int pos);
    if (v > 999) return 8'h40;
`ifdef NUMBER_ON3_7SEG_LZB_EN
    if (pos == 2 && v < 100) return 8'h00;
    if (pos == 1 && v < 10) return 8'h00;
`endif
    return pat_tab[(v / (10 ** pos)) % 10];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int midx;
    int mlat;
    int v;
    int pos;

    // Reset state
    rst_n = 1'b0;
    num   = 10'd42;
    #12;
    check("rst_dig", {5'b0, dig}, 8'h07);
    check("rst_seg", seg, 8'hFF);
    check("rst_dig_ah", {5'b0, dig_ah}, 8'h00);
    check("rst_seg_ah", seg_ah, 8'h00);
    tick();
    check("rst_hold_dig", {5'b0, dig}, 8'h07);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one row per edge, starting at the units edge after release.
    vecs.push_back('{10'd42,   3'b110, 8'hA4});
    vecs.push_back('{10'd42,   3'b101, 8'h99});
    vecs.push_back('{10'd42,   3'b011, LZ});
    vecs.push_back('{10'd42,   3'b110, 8'hA4});
    vecs.push_back('{10'd42,   3'b101, 8'h99});
    vecs.push_back('{10'd42,   3'b011, LZ});
    vecs.push_back('{10'd1000, 3'b110, 8'hBF});
    vecs.push_back('{10'd1000, 3'b101, 8'hBF});
    vecs.push_back('{10'd1000, 3'b011, 8'hBF});
    vecs.push_back('{10'd999,  3'b110, 8'h90});
    vecs.push_back('{10'd999,  3'b101, 8'h90});
    vecs.push_back('{10'd999,  3'b011, 8'h90});
    vecs.push_back('{10'd8,    3'b110, 8'h80});
    vecs.push_back('{10'd8,    3'b101, LZ});
    vecs.push_back('{10'd8,    3'b011, LZ});
    foreach (vecs[i]) begin
      num = vecs[i].num;
      tick();
      check($sformatf("vec%0d_dig", i), {5'b0, dig}, {5'b0, vecs[i].dig});
      check($sformatf("vec%0d_seg", i), seg, vecs[i].seg);
      check($sformatf("vec%0d_dig_ah", i), {5'b0, dig_ah}, {5'b0, ~vecs[i].dig});
      check($sformatf("vec%0d_seg_ah", i), seg_ah, ~vecs[i].seg);
    end

    // Mid-frame change must not tear the current frame.
    num = 10'd123;
    tick();
    check("tear_u3", seg, 8'hB0);
    num = 10'd456;
    tick();
    check("tear_t2", seg, 8'hA4);
    tick();
    check("tear_h1", seg, 8'hF9);
    tick();
    check("tear_u6", seg, 8'h82);
    tick();
    check("tear_t5", seg, 8'h92);
    tick();
    check("tear_h4", seg, 8'h99);

    // Asynchronous reset while on the tens digit.
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_dig", {5'b0, dig}, 8'h07);
    check("async_seg", seg, 8'hFF);
    check("async_seg_ah", seg_ah, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("restart_dig", {5'b0, dig}, 8'h06);
    check("restart_seg", seg, 8'h82);

    // Randomized run against a frame-level model.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    midx = 0;
    mlat = 0;
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 4) == 0) num = 10'($urandom_range(1000, 1023));
        else num = 10'($urandom_range(0, 999));
      end
      @(posedge clk);
      if (midx == 0) mlat = int'(num);
      v    = mlat;
      pos  = midx;
      midx = (midx + 1) % 3;
      #1;
      check($sformatf("rand%0d_dig", c), {5'b0, dig}, {5'b0, ~(3'b001 << pos)});
      check($sformatf("rand%0d_seg", c), seg, ~pattern(v, pos));
      check($sformatf("rand%0d_dig_ah", c), {5'b0, dig_ah}, {5'b0, 3'b001 << pos});
      check($sformatf("rand%0d_seg_ah", c), seg_ah, pattern(v, pos));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
